// File: rtl/vc_pop_arbiter.sv
// rtl/vc_pop_arbiter.sv - weighted round-robin pop arbiter between VC FIFOs and demux_d
//
// Purpose: each cycle decide whether to pop VC0 or VC1 (VC0 weighted, VC1 never
// starved), stall on D-side back-pressure, and re-time the popped word into a
// registered data_out/valid_out pair (2-cycle latency, 1 word/cycle sustained).
//
// Ports:
//   clk, reset_L                      clock, asynchronous active-low reset
//   init                              arbitration enable
//   fifo_empty_vc0/1                  VC FIFO empty flags
//   fifo_pause_d0/1                   D FIFO almost-full flags
//   data_mux_0/1   [DATA_W]           VC read data, valid one cycle after pop
//   pop_vc0/1                         pop requests (combinational, mutually exclusive)
//   data_out [DATA_W], valid_out      registered output word and its one-cycle strobe
//   arb_idle                          idle with nothing in flight
//   gnt_cnt_vc0/1 [CNT_W]             grant counters
//
// Optional feature macro: ARB_STATS_EN enables saturating grant counters;
// when undefined both counter ports are tied to 0.

module vc_pop_arbiter #(
    parameter int DATA_W     = 6,
    parameter int WEIGHT_VC0 = 3,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              init,
    input  logic              fifo_empty_vc0,
    input  logic              fifo_empty_vc1,
    input  logic              fifo_pause_d0,
    input  logic              fifo_pause_d1,
    input  logic [DATA_W-1:0] data_mux_0,
    input  logic [DATA_W-1:0] data_mux_1,
    output logic              pop_vc0,
    output logic              pop_vc1,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              arb_idle,
    output logic [CNT_W-1:0]  gnt_cnt_vc0,
    output logic [CNT_W-1:0]  gnt_cnt_vc1
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_STALL = 2'd2
    } state_t;

    localparam logic [3:0] CREDIT_RELOAD = 4'(WEIGHT_VC0);

    state_t      r_state;
    logic [3:0]  r_credit;
    logic        r_sel;
    logic        r_inflight;

    state_t      w_state;
    logic        w_stall;
    logic        w_any;
    logic        w_serve;
    logic        w_pop0;
    logic        w_pop1;

    // Destination is unknown before the pop, so either D FIFO pausing blocks both VCs.
    assign w_stall = fifo_pause_d0 | fifo_pause_d1;
    assign w_any   = ~fifo_empty_vc0 | ~fifo_empty_vc1;

    always_comb begin
        w_state = ST_IDLE;
        if (init && w_any) begin
            w_state = w_stall ? ST_STALL : ST_SERVE;
        end
    end

    // Pops are gated by reset_L directly so they drop the instant reset asserts.
    assign w_serve = reset_L & (w_state == ST_SERVE);
    assign w_pop0  = w_serve & ~fifo_empty_vc0 & (fifo_empty_vc1 | (r_credit != 4'd0));
    assign w_pop1  = w_serve & ~fifo_empty_vc1 & (fifo_empty_vc0 | (r_credit == 4'd0));

    assign pop_vc0 = w_pop0;
    assign pop_vc1 = w_pop1;

    // r_inflight is always 0 in IDLE, kept explicit to document the drain condition.
    assign arb_idle = (r_state == ST_IDLE) & ~r_inflight;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state    <= ST_IDLE;
            r_credit   <= CREDIT_RELOAD;
            r_sel      <= 1'b0;
            r_inflight <= 1'b0;
            data_out   <= '0;
            valid_out  <= 1'b0;
        end else begin
            r_state <= w_state;

            // Credit is only spent when VC1 is actually competing; any other grant reloads it.
            if (w_pop1 || (w_pop0 && fifo_empty_vc1)) begin
                r_credit <= CREDIT_RELOAD;
            end else if (w_pop0) begin
                r_credit <= r_credit - 4'd1;
            end

            // Stage 1: remember which VC was popped; its read data arrives next cycle.
            r_sel      <= w_pop1;
            r_inflight <= w_pop0 | w_pop1;

            // Stage 2: capture the read data; data_out holds when nothing arrives.
            valid_out <= r_inflight;
            if (r_inflight) begin
                data_out <= r_sel ? data_mux_1 : data_mux_0;
            end
        end
    end

`ifdef ARB_STATS_EN
    logic [CNT_W-1:0] r_gnt_cnt_vc0;
    logic [CNT_W-1:0] r_gnt_cnt_vc1;

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_gnt_cnt_vc0 <= '0;
            r_gnt_cnt_vc1 <= '0;
        end else begin
            if (w_pop0 && (r_gnt_cnt_vc0 != {CNT_W{1'b1}})) begin
                r_gnt_cnt_vc0 <= r_gnt_cnt_vc0 + 1'b1;
            end
            if (w_pop1 && (r_gnt_cnt_vc1 != {CNT_W{1'b1}})) begin
                r_gnt_cnt_vc1 <= r_gnt_cnt_vc1 + 1'b1;
            end
        end
    end

    assign gnt_cnt_vc0 = r_gnt_cnt_vc0;
    assign gnt_cnt_vc1 = r_gnt_cnt_vc1;
`else
    assign gnt_cnt_vc0 = '0;
    assign gnt_cnt_vc1 = '0;
`endif

endmodule

// File: tb/tb_vc_pop_arbiter.sv
// tb/tb_vc_pop_arbiter.sv - self-checking bench for vc_pop_arbiter

module tb_vc_pop_arbiter;

    localparam int DW = 6;
    localparam int W  = 3;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset_L;
    logic          init;
    logic          pause_d0;
    logic          pause_d1;
    logic [DW-1:0] data_mux_0 = '0;
    logic [DW-1:0] data_mux_1 = '0;
    logic          pop_vc0;
    logic          pop_vc1;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          arb_idle;
    logic [CW-1:0] gnt_cnt_vc0;
    logic [CW-1:0] gnt_cnt_vc1;

    always #5 clk = ~clk;

    // Simple FIFO models for the two virtual channels (read data registered on pop).
    logic [DW-1:0] mem0 [0:255];
    logic [DW-1:0] mem1 [0:255];
    int wp0 = 0, rp0 = 0, wp1 = 0, rp1 = 0;
    logic e0, e1;
    assign e0 = (wp0 == rp0);
    assign e1 = (wp1 == rp1);

    always @(posedge clk) begin
        if (pop_vc0 && (wp0 != rp0)) begin
            data_mux_0 <= mem0[rp0[7:0]];
            rp0 <= rp0 + 1;
        end
        if (pop_vc1 && (wp1 != rp1)) begin
            data_mux_1 <= mem1[rp1[7:0]];
            rp1 <= rp1 + 1;
        end
    end

    vc_pop_arbiter #(.DATA_W(DW), .WEIGHT_VC0(W), .CNT_W(CW)) dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .fifo_empty_vc0 (e0),
        .fifo_empty_vc1 (e1),
        .fifo_pause_d0  (pause_d0),
        .fifo_pause_d1  (pause_d1),
        .data_mux_0     (data_mux_0),
        .data_mux_1     (data_mux_1),
        .pop_vc0        (pop_vc0),
        .pop_vc1        (pop_vc1),
        .data_out       (data_out),
        .valid_out      (valid_out),
        .arb_idle       (arb_idle),
        .gnt_cnt_vc0    (gnt_cnt_vc0),
        .gnt_cnt_vc1    (gnt_cnt_vc1)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: expected grants from the weighted round-robin rule,
    // a two-deep queue of popped words for the output, and idle from last cycle's activity.
    int            credit   = W;
    logic          p1v = 0, p2v = 0;
    logic [DW-1:0] p1w = '0, p2w = '0;
    logic [DW-1:0] exp_data = '0;
    logic          exp_idle = 1'b1;
    int            cnt0 = 0, cnt1 = 0;
    logic          log_en = 1'b0;
    int            log_q[$];

    always @(negedge clk) begin
        logic ep0, ep1;
        ep0 = 1'b0;
        ep1 = 1'b0;
        if (reset_L && init && !pause_d0 && !pause_d1) begin
            if (!e0 && e1)       ep0 = 1'b1;
            else if (e0 && !e1)  ep1 = 1'b1;
            else if (!e0 && !e1) begin
                if (credit > 0) ep0 = 1'b1;
                else            ep1 = 1'b1;
            end
        end
        if (!reset_L) begin
            chk("rst_pop_vc0", pop_vc0, 0);
            chk("rst_pop_vc1", pop_vc1, 0);
            chk("rst_valid", valid_out, 0);
            chk("rst_data", data_out, 0);
            chk("rst_idle", arb_idle, 1);
            chk("rst_cnt0", gnt_cnt_vc0, 0);
            chk("rst_cnt1", gnt_cnt_vc1, 0);
            credit = W; p1v = 0; p2v = 0; exp_data = '0; exp_idle = 1'b1;
            cnt0 = 0; cnt1 = 0;
        end else begin
            chk("pop_vc0", pop_vc0, ep0);
            chk("pop_vc1", pop_vc1, ep1);
            chk("valid_out", valid_out, p2v);
            if (p2v) exp_data = p2w;
            chk("data_out", data_out, exp_data);
            chk("arb_idle", arb_idle, exp_idle);
`ifdef ARB_STATS_EN
            chk("gnt_cnt_vc0", gnt_cnt_vc0, cnt0);
            chk("gnt_cnt_vc1", gnt_cnt_vc1, cnt1);
`else
            chk("gnt_cnt_vc0", gnt_cnt_vc0, 0);
            chk("gnt_cnt_vc1", gnt_cnt_vc1, 0);
`endif
            p2v = p1v;
            p2w = p1w;
            p1v = ep0 | ep1;
            p1w = ep0 ? mem0[rp0[7:0]] : mem1[rp1[7:0]];
            if (ep0) credit = e1 ? W : credit - 1;
            if (ep1) credit = W;
            if (ep0) cnt0++;
            if (ep1) cnt1++;
            exp_idle = !(init && (!e0 || !e1));
            if (log_en && (pop_vc0 || pop_vc1)) log_q.push_back(pop_vc1 ? 1 : 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push0(input logic [DW-1:0] w);
        mem0[wp0[7:0]] = w;
        wp0++;
    endtask

    task automatic push1(input logic [DW-1:0] w);
        mem1[wp1[7:0]] = w;
        wp1++;
    endtask

    task automatic wait_drain();
        logic done;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (e0 && e1 && arb_idle && !valid_out) done = 1'b1;
        end
        chk("drain_timeout", done, 1);
        tick();
    endtask

    task automatic check_order(input string name, input int exp_order[]);
        chk({name, "_len"}, log_q.size(), exp_order.size());
        for (int i = 0; i < exp_order.size() && i < log_q.size(); i++) begin
            chk($sformatf("%s_%0d", name, i), log_q[i], exp_order[i]);
        end
    endtask

    initial begin
        int exp2[];
        int exp4[];
        int vcount, first, last, popcnt;

        // Scenario 1: reset held with VC0 non-empty and init=1.
        reset_L = 1'b0; init = 1'b1; pause_d0 = 1'b0; pause_d1 = 1'b0;
        push0(6'h05);
        tick(); tick();
        @(negedge clk);
        chk("s1_pop_in_reset", pop_vc0, 0);
        chk("s1_idle_in_reset", arb_idle, 1);
        tick();
        reset_L = 1'b1;
        @(negedge clk);
        chk("s1_first_pop", pop_vc0, 1);
        tick();
        wait_drain();

        // Scenario 2: 8 VC0 words, 4 VC1 words, weight 3.
        reset_L = 1'b0; init = 1'b0;
        for (int i = 0; i < 8; i++) push0(6'h10 + 6'(i));
        for (int i = 0; i < 4; i++) push1(6'h20 + 6'(i));
        tick();
        reset_L = 1'b1;
        tick();
        log_q.delete();
        log_en = 1'b1;
        init = 1'b1;
        vcount = 0; first = -1; last = -1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (valid_out) begin
                vcount++;
                if (first < 0) first = c;
                last = c;
            end
        end
        tick();
        log_en = 1'b0;
        exp2 = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 1, 1};
        check_order("s2_order", exp2);
        chk("s2_valid_count", vcount, 12);
        chk("s2_first_valid", first, 2);
        chk("s2_back_to_back", last - first, 11);
`ifdef ARB_STATS_EN
        chk("s6_cnt0", gnt_cnt_vc0, 8);
        chk("s6_cnt1", gnt_cnt_vc1, 4);
`else
        chk("s6_cnt0", gnt_cnt_vc0, 0);
        chk("s6_cnt1", gnt_cnt_vc1, 0);
`endif
        wait_drain();

        // Scenario 3: VC0 streaming with a 5-cycle pause on D1.
        for (int i = 0; i < 12; i++) push0(6'h08 + 6'(i));
        tick(); tick(); tick();
        pause_d1 = 1'b1;
        popcnt = 0; vcount = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (pop_vc0 || pop_vc1) popcnt++;
            if (valid_out) vcount++;
            tick();
        end
        pause_d1 = 1'b0;
        chk("s3_pops_in_pause", popcnt, 0);
        chk("s3_inflight_out", vcount, 2);
        @(negedge clk);
        chk("s3_resume_pop", pop_vc0, 1);
        tick();
        wait_drain();

        // Scenario 4: VC1-only burst, then both VCs to confirm the credit was reloaded.
        log_q.delete();
        log_en = 1'b1;
        for (int i = 0; i < 3; i++) push1(6'h31 + 6'(i));
        wait_drain();
        for (int i = 0; i < 4; i++) push0(6'h18 + 6'(i));
        for (int i = 0; i < 2; i++) push1(6'h2a + 6'(i));
        wait_drain();
        log_en = 1'b0;
        exp4 = '{1, 1, 1, 0, 0, 0, 1, 0, 1};
        check_order("s4_order", exp4);

        // Scenario 5: init dropped with one word in flight.
        init = 1'b0;
        for (int i = 0; i < 5; i++) push0(6'h3a + 6'(i));
        tick();
        init = 1'b1;
        @(negedge clk);
        chk("s5_pop", pop_vc0, 1);
        tick();
        init = 1'b0;
        @(negedge clk);
        chk("s5_no_pop", pop_vc0, 0);
        chk("s5_busy", arb_idle, 0);
        tick();
        @(negedge clk);
        chk("s5_valid", valid_out, 1);
        chk("s5_data", data_out, 6'h3a);
        chk("s5_idle", arb_idle, 1);
        tick(); tick();
        @(negedge clk);
        chk("s5_still_no_pop", pop_vc0, 0);
        tick();
        init = 1'b1;
        wait_drain();

        // Reset mid-stream: in-flight words are dropped at once.
        for (int i = 0; i < 6; i++) push0(6'h01 + 6'(i));
        tick(); tick(); tick();
        reset_L = 1'b0;
        #1;
        chk("rst_mid_valid", valid_out, 0);
        chk("rst_mid_pop", pop_vc0, 0);
        tick();
        reset_L = 1'b1;
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
